mc_control_fsm: RTL

//   Multicycle RV32I control unit. Drives the 3-bit ALU control code and the

---
 rtl/mc_control_fsm_if.sv | 37 +++
 rtl/mc_control_fsm.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle control FSM and the RV32I datapath.
// The master side is the control unit; the slave side is the datapath
// (instruction register fields, ALU flag, memory handshake).
interface mc_control_fsm_if #(
    parameter int ALU_CTRL_WIDTH = 3
);
    // Instruction fields and datapath status
    logic [6:0]                op;
    logic [2:0]                funct3;
    logic                      funct7_5;
    logic                      EQ;
    logic                      mem_ready;

    // Control outputs towards the datapath
    logic                      PCWrite;
    logic                      AdrSrc;
    logic                      MemWrite;
    logic                      IRWrite;
    logic [1:0]                ResultSrc;
    logic [1:0]                ALUSrcA;
    logic [1:0]                ALUSrcB;
    logic                      RegWrite;
    logic [ALU_CTRL_WIDTH-1:0] ALUctrl;
    logic                      illegal_instr;

    modport master (
        input  op, funct3, funct7_5, EQ, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
               ALUSrcA, ALUSrcB, RegWrite, ALUctrl, illegal_instr
    );

    modport slave (
        output op, funct3, funct7_5, EQ, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
               ALUSrcA, ALUSrcB, RegWrite, ALUctrl, illegal_instr
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I control unit. Moore FSM sequencing
// FETCH/DECODE/EXECUTE/MEM/WRITEBACK; ALUctrl in the execute states is
// additionally decoded from funct3/funct7_5. Write enables are gated by
// rst_n so nothing can be written while reset is asserted.
module mc_control_fsm #(
    parameter int ALU_CTRL_WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    mc_control_fsm_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_JAL,
        S_BEQ
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLT = 3'b101;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OR  = 3'b011;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_AND = 3'b010;

    // Mux select encodings
    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_OLDPC  = 2'b01;
    localparam logic [1:0] SRCA_RS1    = 2'b10;
    localparam logic [1:0] SRCB_RS2    = 2'b00;
    localparam logic [1:0] SRCB_IMM    = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;
    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALURES  = 2'b10;

    state_t                    r_state;
    state_t                    w_next_state;
    logic                      r_illegal;
    logic                      w_illegal_set;

    logic [ALU_CTRL_WIDTH-1:0] w_funct_alu;
    logic                      w_funct_ok;

    logic                      w_pc_write;
    logic                      w_adr_src;
    logic                      w_mem_write;
    logic                      w_ir_write;
    logic [1:0]                w_result_src;
    logic [1:0]                w_alu_src_a;
    logic [1:0]                w_alu_src_b;
    logic                      w_reg_write;
    logic [ALU_CTRL_WIDTH-1:0] w_alu_ctrl;

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Registered illegal-instruction pulse, high the cycle after detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= w_illegal_set;
        end
    end

    // funct3/funct7_5 to ALU code; funct7_5 selects sub only for R-type
    always_comb begin
        w_funct_alu = ALU_ADD;
        w_funct_ok  = 1'b1;
        case (bus.funct3)
            3'b000: begin
                if ((r_state == S_EXECUTER) && bus.funct7_5) begin
                    w_funct_alu = ALU_SUB;
                end
            end
            3'b010:  w_funct_alu = ALU_SLT;
            3'b110:  w_funct_alu = ALU_OR;
            3'b111:  w_funct_alu = ALU_AND;
            default: w_funct_ok  = 1'b0;
        endcase
    end

    // Next-state logic and Moore output decode
    always_comb begin
        w_next_state  = r_state;
        w_illegal_set = 1'b0;
        w_pc_write    = 1'b0;
        w_adr_src     = 1'b0;
        w_mem_write   = 1'b0;
        w_ir_write    = 1'b0;
        w_result_src  = RES_ALUOUT;
        w_alu_src_a   = SRCA_PC;
        w_alu_src_b   = SRCB_RS2;
        w_reg_write   = 1'b0;
        w_alu_ctrl    = ALU_ADD;

        case (r_state)
            S_FETCH: begin
                // PC+4 computed while the instruction is read
                w_adr_src    = 1'b0;
                w_alu_src_a  = SRCA_PC;
                w_alu_src_b  = SRCB_FOUR;
                w_result_src = RES_ALURES;
                w_ir_write   = bus.mem_ready;
                w_pc_write   = bus.mem_ready;
                if (bus.mem_ready) begin
                    w_next_state = S_DECODE;
                end
            end

            S_DECODE: begin
                // Branch target OldPC+imm lands in ALUOut for BEQ/JAL
                w_alu_src_a = SRCA_OLDPC;
                w_alu_src_b = SRCB_IMM;
                case (bus.op)
                    OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
                    OP_RTYPE:          w_next_state = S_EXECUTER;
                    OP_ITYPE:          w_next_state = S_EXECUTEI;
                    OP_JAL:            w_next_state = S_JAL;
                    OP_BRANCH: begin
                        if (bus.funct3 == 3'b000) begin
                            w_next_state = S_BEQ;
                        end else begin
                            w_next_state  = S_FETCH;
                            w_illegal_set = 1'b1;
                        end
                    end
                    default: begin
                        w_next_state  = S_FETCH;
                        w_illegal_set = 1'b1;
                    end
                endcase
            end

            S_MEMADR: begin
                w_alu_src_a  = SRCA_RS1;
                w_alu_src_b  = SRCB_IMM;
                w_next_state = (bus.op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end

            S_MEMREAD: begin
                w_adr_src    = 1'b1;
                w_result_src = RES_ALUOUT;
                if (bus.mem_ready) begin
                    w_next_state = S_MEMWB;
                end
            end

            S_MEMWB: begin
                w_result_src = RES_MEMDATA;
                w_reg_write  = 1'b1;
                w_next_state = S_FETCH;
            end

            S_MEMWRITE: begin
                // Strobe held until the memory acknowledges the store
                w_adr_src    = 1'b1;
                w_result_src = RES_ALUOUT;
                w_mem_write  = 1'b1;
                if (bus.mem_ready) begin
                    w_next_state = S_FETCH;
                end
            end

            S_EXECUTER, S_EXECUTEI: begin
                w_alu_src_a = SRCA_RS1;
                w_alu_src_b = (r_state == S_EXECUTER) ? SRCB_RS2 : SRCB_IMM;
                w_alu_ctrl  = w_funct_alu;
                if (w_funct_ok) begin
                    w_next_state = S_ALUWB;
                end else begin
                    // Unsupported funct3 skips writeback entirely
                    w_next_state  = S_FETCH;
                    w_illegal_set = 1'b1;
                end
            end

            S_ALUWB: begin
                w_result_src = RES_ALUOUT;
                w_reg_write  = 1'b1;
                w_next_state = S_FETCH;
            end

            S_JAL: begin
                // PC <- target from ALUOut; ALU forms OldPC+4 for rd
                w_alu_src_a  = SRCA_OLDPC;
                w_alu_src_b  = SRCB_FOUR;
                w_result_src = RES_ALUOUT;
                w_pc_write   = 1'b1;
                w_next_state = S_ALUWB;
            end

            S_BEQ: begin
                w_alu_src_a  = SRCA_RS1;
                w_alu_src_b  = SRCB_RS2;
                w_alu_ctrl   = ALU_SUB;
                w_result_src = RES_ALUOUT;
                w_pc_write   = bus.EQ;
                w_next_state = S_FETCH;
            end

            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    // Write enables are forced low for as long as reset is held
    assign bus.PCWrite       = w_pc_write  & rst_n;
    assign bus.IRWrite       = w_ir_write  & rst_n;
    assign bus.MemWrite      = w_mem_write & rst_n;
    assign bus.RegWrite      = w_reg_write & rst_n;
    assign bus.AdrSrc        = w_adr_src;
    assign bus.ResultSrc     = w_result_src;
    assign bus.ALUSrcA       = w_alu_src_a;
    assign bus.ALUSrcB       = w_alu_src_b;
    assign bus.ALUctrl       = w_alu_ctrl;
    assign bus.illegal_instr = r_illegal;

endmodule
